// File: rtl/tlda_pkg.sv
// Shared definitions for the thick-line draw accelerator: screen geometry,
// internal coordinate widths, the latched line command and the FSM states.
package tlda_pkg;

    localparam int unsigned SCREEN_W        = 320;
    localparam int unsigned SCREEN_H        = 240;
    localparam int unsigned ROW_STRIDE      = 1024;
    localparam int unsigned BYTES_PER_PIXEL = 2;

    localparam int unsigned X_W     = 9;
    localparam int unsigned Y_W     = 8;
    localparam int unsigned T_W     = 9;
    localparam int unsigned COLOR_W = 16;
    localparam int unsigned ADDR_W  = 32;

    // Signed centre-line coordinates; wide enough for spans hanging off-screen.
    localparam int unsigned COORD_W = 11;
    // Bresenham error term, including the doubled value used for decisions.
    localparam int unsigned ERR_W   = 13;
    // Span index must reach T (up to 511) to detect span exhaustion.
    localparam int unsigned SPAN_W  = T_W + 1;

    typedef logic signed [COORD_W-1:0] coord_t;

    // Operands captured at start; later input changes are ignored.
    typedef struct packed {
        logic [X_W-1:0]     x0;
        logic [Y_W-1:0]     y0;
        logic [X_W-1:0]     x1;
        logic [Y_W-1:0]     y1;
        logic [T_W-1:0]     thickness;
        logic [COLOR_W-1:0] color;
        logic [ADDR_W-1:0]  base;
    } line_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_SPAN    = 3'd2,
        S_PIXEL   = 3'd3,
        S_RELEASE = 3'd4,
        S_STEP    = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

endpackage

// File: rtl/tlda_bresenham_stepper.sv
// Centre-line walker: integer Bresenham over all octants from (x0,y0) to
// (x1,y1) inclusive.
//   init    : load start point, deltas, error and step count from endpoints
//   advance : move one point along the line
//   cx, cy  : current centre point
//   x_major : |dx| >= |dy| (span runs vertically)
//   last    : current point is the endpoint
module tlda_bresenham_stepper
    import tlda_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    input  logic   init,
    input  logic   advance,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output coord_t cx,
    output coord_t cy,
    output logic   x_major,
    output logic   last
);

    coord_t                   cx_q, cy_q, dx_q, dy_q;
    logic                     sx_neg_q, sy_neg_q;
    logic signed [ERR_W-1:0]  err_q;
    logic [COORD_W-1:0]       cnt_q;
    logic                     x_major_q, last_q;

    coord_t                   diff_x, diff_y, adx, ady, span_len;
    logic signed [ERR_W-1:0]  dx_e, dy_e, e2, err_n;
    coord_t                   cx_n, cy_n;

    // Endpoint deltas, evaluated when init is pulsed.
    assign diff_x   = x1 - x0;
    assign diff_y   = y1 - y0;
    assign adx      = diff_x[COORD_W-1] ? -diff_x : diff_x;
    assign ady      = diff_y[COORD_W-1] ? -diff_y : diff_y;
    assign span_len = (adx >= ady) ? adx : ady;

    assign dx_e = ERR_W'(dx_q);
    assign dy_e = ERR_W'(dy_q);

    // One Bresenham step; both decisions use the pre-step doubled error.
    always_comb begin : step_calc
        e2    = err_q <<< 1;
        err_n = err_q;
        cx_n  = cx_q;
        cy_n  = cy_q;
        if (e2 >= -dy_e) begin
            err_n = err_n - dy_e;
            cx_n  = sx_neg_q ? (cx_q - coord_t'(1)) : (cx_q + coord_t'(1));
        end
        if (e2 <= dx_e) begin
            err_n = err_n + dx_e;
            cy_n  = sy_neg_q ? (cy_q - coord_t'(1)) : (cy_q + coord_t'(1));
        end
    end

    // Walker state.
    always_ff @(posedge clk or negedge resetn) begin : step_regs
        if (!resetn) begin
            cx_q      <= '0;
            cy_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            err_q     <= '0;
            cnt_q     <= '0;
            x_major_q <= 1'b0;
            last_q    <= 1'b0;
        end else if (init) begin
            cx_q      <= x0;
            cy_q      <= y0;
            dx_q      <= adx;
            dy_q      <= ady;
            sx_neg_q  <= diff_x[COORD_W-1];
            sy_neg_q  <= diff_y[COORD_W-1];
            err_q     <= ERR_W'(adx) - ERR_W'(ady);
            cnt_q     <= span_len;
            x_major_q <= (adx >= ady);
            last_q    <= (span_len == '0);
        end else if (advance) begin
            cx_q   <= cx_n;
            cy_q   <= cy_n;
            err_q  <= err_n;
            cnt_q  <= cnt_q - COORD_W'(1);
            last_q <= (cnt_q == COORD_W'(1));
        end
    end

    assign cx      = cx_q;
    assign cy      = cy_q;
    assign x_major = x_major_q;
    assign last    = last_q;

endmodule

// File: rtl/tlda_circuit.sv
// Thick-line draw engine: walks a Bresenham centre line and, at each point,
// emits a perpendicular span of pixels to an external writer over a
// four-phase Draw/Write_Finish handshake. Off-screen pixels are skipped.
//   clk, resetn        : clock, async active-low reset
//   Go                 : start (level, sampled in IDLE)
//   X0,Y0,X1,Y1        : line endpoints
//   Thickness          : span width (0 behaves as 1)
//   Color              : pixel colour, latched only
//   Base_Addr          : pixel-buffer base byte address
//   Write_Finish       : writer acknowledge
//   Draw/Pixel_Address : pixel write request and its byte address
//   Done               : line complete, held until next start
module tlda_circuit
    import tlda_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               Go,
    input  logic [X_W-1:0]     X0,
    input  logic [Y_W-1:0]     Y0,
    input  logic [X_W-1:0]     X1,
    input  logic [Y_W-1:0]     Y1,
    input  logic [T_W-1:0]     Thickness,
    input  logic [COLOR_W-1:0] Color,
    input  logic [ADDR_W-1:0]  Base_Addr,
    input  logic               Write_Finish,
    output logic               Draw,
    output logic [ADDR_W-1:0]  Pixel_Address,
    output logic               Done
);

    state_t             state_q, state_d;
    line_cmd_t          cmd_q, cmd_d;
    logic [SPAN_W-1:0]  span_q, span_d;
    logic               draw_q, draw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               done_q, done_d;

    logic               step_init, step_adv;
    coord_t             cx, cy;
    logic               x_major, step_last;

    logic [T_W-1:0]     t_eff;
    coord_t             half_t, span_off, minor, px, py;
    logic               pix_ok;
    logic [ADDR_W-1:0]  pix_addr;
    logic               unused_color;

    // Colour only travels with the command; it never reaches addressing.
    assign unused_color = ^cmd_q.color;

    tlda_bresenham_stepper u_stepper (
        .clk     (clk),
        .resetn  (resetn),
        .init    (step_init),
        .advance (step_adv),
        .x0      (coord_t'({2'b00, cmd_q.x0})),
        .y0      (coord_t'({3'b000, cmd_q.y0})),
        .x1      (coord_t'({2'b00, cmd_q.x1})),
        .y1      (coord_t'({3'b000, cmd_q.y1})),
        .cx      (cx),
        .cy      (cy),
        .x_major (x_major),
        .last    (step_last)
    );

    // Candidate span pixel: offset along the minor axis from the centre point.
    assign t_eff    = (cmd_q.thickness == '0) ? T_W'(1) : cmd_q.thickness;
    assign half_t   = coord_t'(COORD_W'(t_eff >> 1));
    assign span_off = coord_t'(COORD_W'(span_q));
    assign minor    = (x_major ? cy : cx) - half_t + span_off;
    assign px       = x_major ? cx : minor;
    assign py       = x_major ? minor : cy;

    assign pix_ok = !px[COORD_W-1] && (px < COORD_W'(SCREEN_W)) &&
                    !py[COORD_W-1] && (py < COORD_W'(SCREEN_H));

    assign pix_addr = cmd_q.base
                    + ADDR_W'(py[Y_W-1:0]) * ADDR_W'(ROW_STRIDE)
                    + ADDR_W'(px[X_W-1:0]) * ADDR_W'(BYTES_PER_PIXEL);

    // State and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin : fsm_regs
        if (!resetn) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            span_q  <= '0;
            draw_q  <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            span_q  <= span_d;
            draw_q  <= draw_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    // Next state, next outputs, stepper controls.
    always_comb begin : fsm_next
        state_d   = state_q;
        cmd_d     = cmd_q;
        span_d    = span_q;
        draw_d    = draw_q;
        addr_d    = addr_q;
        done_d    = done_q;
        step_init = 1'b0;
        step_adv  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Go) begin
                    cmd_d = '{x0: X0, y0: Y0, x1: X1, y1: Y1,
                              thickness: Thickness, color: Color,
                              base: Base_Addr};
                    done_d  = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                step_init = 1'b1;
                span_d    = '0;
                state_d   = S_SPAN;
            end
            S_SPAN: begin
                // One candidate per cycle; clipped pixels just advance the index.
                if (span_q >= SPAN_W'(t_eff)) begin
                    state_d = S_STEP;
                end else if (pix_ok) begin
                    addr_d  = pix_addr;
                    draw_d  = 1'b1;
                    state_d = S_PIXEL;
                end else begin
                    span_d = span_q + SPAN_W'(1);
                end
            end
            S_PIXEL: begin
                if (Write_Finish) begin
                    draw_d  = 1'b0;
                    span_d  = span_q + SPAN_W'(1);
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!Write_Finish) begin
                    state_d = S_SPAN;
                end
            end
            S_STEP: begin
                if (step_last) begin
                    state_d = S_FINISH;
                end else begin
                    step_adv = 1'b1;
                    span_d   = '0;
                    state_d  = S_SPAN;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Draw          = draw_q;
    assign Pixel_Address = addr_q;
    assign Done          = done_q;

endmodule

// File: tb/tb_tlda_circuit.sv
// Directed bench for tlda_circuit: hand-computed address lists per line,
// handshake stall/hold behaviour and asynchronous reset.
module tb_tlda_circuit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        Go = 1'b0;
    logic [8:0]  X0 = '0, X1 = '0, Thickness = '0;
    logic [7:0]  Y0 = '0, Y1 = '0;
    logic [15:0] Color = '0;
    logic [31:0] Base_Addr = '0;
    logic        Write_Finish = 1'b0;
    logic        Draw;
    logic [31:0] Pixel_Address;
    logic        Done;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    tlda_circuit dut (
        .clk           (clk),
        .resetn        (resetn),
        .Go            (Go),
        .X0            (X0),
        .X1            (X1),
        .Y0            (Y0),
        .Y1            (Y1),
        .Thickness     (Thickness),
        .Color         (Color),
        .Base_Addr     (Base_Addr),
        .Write_Finish  (Write_Finish),
        .Draw          (Draw),
        .Pixel_Address (Pixel_Address),
        .Done          (Done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch a line, then scramble the inputs to show they are not re-read.
    task automatic start_line(input logic [8:0] x0, input logic [7:0] y0,
                              input logic [8:0] x1, input logic [7:0] y1,
                              input logic [8:0] t, input logic [31:0] base);
        @(negedge clk);
        X0 = x0; Y0 = y0; X1 = x1; Y1 = y1;
        Thickness = t; Base_Addr = base; Color = 16'hF81F;
        Go = 1'b1;
        @(negedge clk);
        Go = 1'b0;
        X0 = 9'h1AB; Y0 = 8'h77; X1 = 9'h055; Y1 = 8'h33;
        Thickness = 9'd7; Base_Addr = 32'hDEAD_0000; Color = 16'h0;
    endtask

    // Act as the pixel writer, recording every requested address.
    task automatic run_line(input int budget, input bit expect_done);
        int n;
        bit fin;
        n = 0;
        fin = 1'b0;
        got_q.delete();
        while (n < budget && !fin) begin
            @(negedge clk);
            n++;
            if (Done) fin = 1'b1;
            else if (Draw && !Write_Finish) begin
                got_q.push_back(Pixel_Address);
                Write_Finish = 1'b1;
            end else if (!Draw && Write_Finish) begin
                Write_Finish = 1'b0;
            end
        end
        if (expect_done) check_eq("done_reached", 32'(fin), 32'd1);
    endtask

    task automatic check_list(input string tag);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        bit          flag;
        int          draws, dones;
        logic        prev_done;

        // Reset state and quiet after release.
        repeat (3) @(negedge clk);
        check_eq("rst_draw", 32'(Draw), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        check_eq("rst_addr", Pixel_Address, 32'd0);
        resetn = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (Draw) flag = 1'b1;
        end
        check_eq("no_draw_without_go", 32'(flag), 32'd0);

        // Horizontal thin line.
        start_line(9'd0, 8'd0, 9'd3, 8'd0, 9'd1, 32'h0);
        run_line(300, 1'b1);
        exp_q = '{32'h0, 32'h2, 32'h4, 32'h6};
        check_list("hline");
        repeat (3) @(negedge clk);
        check_eq("done_held", 32'(Done), 32'd1);

        // Diagonal and reversed horizontal.
        start_line(9'd0, 8'd0, 9'd3, 8'd3, 9'd1, 32'h0);
        run_line(300, 1'b1);
        exp_q = '{32'h000, 32'h402, 32'h804, 32'hC06};
        check_list("diag");

        start_line(9'd3, 8'd0, 9'd0, 8'd0, 9'd1, 32'h0);
        run_line(300, 1'b1);
        exp_q = '{32'h6, 32'h4, 32'h2, 32'h0};
        check_list("hrev");

        // Degenerate point with zero thickness.
        start_line(9'd5, 8'd5, 9'd5, 8'd5, 9'd0, 32'h0);
        run_line(300, 1'b1);
        exp_q = '{32'h140A};
        check_list("point");

        // Vertical line, thickness 10, left half of each span clipped.
        start_line(9'd0, 8'd0, 9'd0, 8'd3, 9'd10, 32'h0900_0000);
        run_line(1000, 1'b1);
        exp_q.delete();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++)
                exp_q.push_back(32'h0900_0000 + 32'(y) * 32'd1024 + 32'(x) * 32'd2);
        check_list("thick");
        if (got_q.size() == 20) begin
            check_eq("thick_first", got_q[0], 32'h0900_0000);
            check_eq("thick_row1", got_q[5], 32'h0900_0400);
            check_eq("thick_last", got_q[19], 32'h0900_0C08);
        end

        // Fully off-screen line.
        start_line(9'd400, 8'd10, 9'd400, 8'd12, 9'd1, 32'h0);
        run_line(300, 1'b1);
        exp_q.delete();
        check_list("offscreen");

        // Bottom-right corner, span crosses the lower edge.
        start_line(9'd319, 8'd239, 9'd319, 8'd239, 9'd3, 32'h0);
        run_line(300, 1'b1);
        exp_q = '{32'h3BA7E, 32'h3BE7E};
        check_list("corner");

        // Writer stalls: request must hold steady.
        start_line(9'd0, 8'd0, 9'd1, 8'd0, 9'd1, 32'h100);
        flag = 1'b0;
        for (int i = 0; i < 20 && !flag; i++) begin
            @(negedge clk);
            if (Draw) flag = 1'b1;
        end
        check_eq("stall_draw_seen", 32'(flag), 32'd1);
        held = Pixel_Address;
        check_eq("stall_addr", held, 32'h100);
        flag = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (!Draw || Pixel_Address !== held) flag = 1'b1;
        end
        check_eq("stall_stable", 32'(flag), 32'd0);
        Write_Finish = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("ack_draw_drop", 32'(Draw), 32'd0);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (Draw) flag = 1'b1;
        end
        check_eq("ack_held_no_req", 32'(flag), 32'd0);
        Write_Finish = 1'b0;
        run_line(300, 1'b1);
        exp_q = '{32'h102};
        check_list("after_stall");

        // Reset in the middle of a long line.
        start_line(9'd0, 8'd0, 9'd300, 8'd0, 9'd1, 32'h0);
        run_line(25, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 10 && !flag; i++) begin
            @(negedge clk);
            if (Draw && !Write_Finish) flag = 1'b1;
            else if (!Draw && Write_Finish) Write_Finish = 1'b0;
        end
        check_eq("midline_draw_seen", 32'(flag), 32'd1);
        resetn = 1'b0;
        Write_Finish = 1'b0;
        #1;
        check_eq("midrst_draw", 32'(Draw), 32'd0);
        check_eq("midrst_done", 32'(Done), 32'd0);
        check_eq("midrst_addr", Pixel_Address, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (Draw || Done) flag = 1'b1;
        end
        check_eq("midrst_idle", 32'(flag), 32'd0);

        start_line(9'd1, 8'd1, 9'd1, 8'd1, 9'd1, 32'h0);
        run_line(300, 1'b1);
        exp_q = '{32'h402};
        check_list("post_rst");
        check_eq("done_before_rst", 32'(Done), 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("rst_clears_done", 32'(Done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Go held through completion restarts the line.
        @(negedge clk);
        X0 = 9'd2; Y0 = 8'd0; X1 = 9'd2; Y1 = 8'd0;
        Thickness = 9'd1; Base_Addr = 32'h0;
        Go = 1'b1;
        draws = 0;
        dones = 0;
        flag = 1'b0;
        prev_done = Done;
        repeat (60) begin
            @(negedge clk);
            if (Done && !prev_done) dones++;
            prev_done = Done;
            if (Draw && !Write_Finish) begin
                draws++;
                if (Pixel_Address !== 32'h4) flag = 1'b1;
                Write_Finish = 1'b1;
            end else if (!Draw && Write_Finish) begin
                Write_Finish = 1'b0;
            end
        end
        Go = 1'b0;
        check_eq("go_held_multi", 32'(draws >= 2), 32'd1);
        check_eq("go_held_done", 32'(dones >= 1), 32'd1);
        check_eq("go_held_addr", 32'(flag), 32'd0);
        run_line(300, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
